// File: rtl/udp_receiver_if.sv
// rtl/udp_receiver_if.sv - MAC RX word stream and payload memory write port of udp_receiver
interface udp_receiver_if #(parameter int ADDR_W = 11);
    logic [31:0]       rx_data;
    logic              rx_sop;
    logic              rx_eop;
    logic              rx_dval;
    logic              rx_err;
    logic              rx_rdy;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_adr_wr;
    logic [31:0]       mem_data_wr;

    // Frame source / payload memory side
    modport master (
        output rx_data, rx_sop, rx_eop, rx_dval, rx_err,
        input  rx_rdy,
        input  mem_wr, mem_adr_wr, mem_data_wr
    );

    // Receiver side
    modport slave (
        input  rx_data, rx_sop, rx_eop, rx_dval, rx_err,
        output rx_rdy,
        output mem_wr, mem_adr_wr, mem_data_wr
    );
endinterface

// File: rtl/udp_receiver.sv
// rtl/udp_receiver.sv - IPv4/UDP frame parser writing datagram payload to word memory
module udp_receiver #(
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                rst,
    udp_receiver_if.slave       bus,
    input  logic [47:0]         mac,
    input  logic [31:0]         ip_local,
    input  logic [15:0]         port_local,
    output logic [15:0]         rx_length,
    output logic [31:0]         src_ip,
    output logic [15:0]         src_port,
    output logic [7:0]          channel,
    output logic [31:0]         time_buf,
    output logic                RX_DONE,
    output logic                RX_DROP,
    output logic [2:0]          drop_cause
);
    localparam int NW = ADDR_W + 1;
    localparam logic [31:0] LEN_MAX = 32'(4 * (2 ** ADDR_W) + 14);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DISCARD, COMMIT} state_t;
    state_t state, state_n;

    logic          acc;
    logic [3:0]    wcnt;
    logic          mac_uni_q, mac_bc_q;
    logic [15:0]   dip_hi_q;
    logic [19:0]   csum_acc;
    logic [19:0]   csum_sum;
    logic [16:0]   csum_f1;
    logic [15:0]   csum_f2;
    logic [NW-1:0] n_words, pay_k, k_next;
    logic [2:0]    cause_q;
    logic [15:0]   plen_q, sport_q;
    logic [31:0]   sip_q, time_q;
    logic [7:0]    chan_q;

    logic          hdr_fail;
    logic [2:0]    hdr_cause;
    logic          drop_now, commit_now, go_discard;
    logic [2:0]    drop_code;

    assign acc      = bus.rx_dval & bus.rx_rdy;
    assign csum_sum = csum_acc + {4'b0, bus.rx_data[31:16]};
    assign csum_f1  = {1'b0, csum_sum[15:0]} + {13'b0, csum_sum[19:16]};
    assign csum_f2  = csum_f1[15:0] + {15'b0, csum_f1[16]};
    assign k_next   = (pay_k < n_words) ? pay_k + NW'(1) : pay_k;

    // Header field check for the word currently offered in HDR
    always_comb begin
        hdr_fail  = 1'b0;
        hdr_cause = 3'd0;
        case (wcnt)
            4'd1: if (!((mac_uni_q && bus.rx_data[31:16] == {mac[39:32], mac[47:40]}) ||
                        (mac_bc_q && bus.rx_data[31:16] == 16'hFFFF))) begin
                      hdr_fail = 1'b1; hdr_cause = 3'd1;
                  end
            4'd3: if (bus.rx_data[31:16] != 16'h0800 || bus.rx_data[15:8] != 8'h45) begin
                      hdr_fail = 1'b1; hdr_cause = 3'd2;
                  end
            4'd5: if (bus.rx_data[7:0] != 8'h11) begin
                      hdr_fail = 1'b1; hdr_cause = 3'd3;
                  end
            4'd8: if ({dip_hi_q, bus.rx_data[31:16]} != ip_local) begin
                      hdr_fail = 1'b1; hdr_cause = 3'd4;
                  end else if (csum_f2 != 16'hFFFF) begin
                      hdr_fail = 1'b1; hdr_cause = 3'd6;
                  end
            4'd9: if (bus.rx_data[31:16] != port_local) begin
                      hdr_fail = 1'b1; hdr_cause = 3'd5;
                  end else if (bus.rx_data[15:0] < 16'd14 || {16'd0, bus.rx_data[15:0]} > LEN_MAX) begin
                      hdr_fail = 1'b1; hdr_cause = 3'd2;
                  end
            default: ;
        endcase
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state plus drop/commit decisions; a new sop always restarts parsing
    always_comb begin
        state_n    = state;
        drop_now   = 1'b0;
        drop_code  = cause_q;
        commit_now = 1'b0;
        go_discard = 1'b0;
        if (state == COMMIT) begin
            state_n = IDLE;
        end else if (acc && bus.rx_sop) begin
            drop_now  = (state != IDLE) || bus.rx_eop;
            drop_code = 3'd7;
            state_n   = bus.rx_eop ? IDLE : HDR;
        end else if (acc) begin
            case (state)
                HDR: begin
                    if (bus.rx_eop && bus.rx_err) begin
                        drop_now = 1'b1; drop_code = 3'd7; state_n = IDLE;
                    end else if (hdr_fail) begin
                        if (bus.rx_eop) begin
                            drop_now = 1'b1; drop_code = hdr_cause; state_n = IDLE;
                        end else begin
                            go_discard = 1'b1; state_n = DISCARD;
                        end
                    end else if (bus.rx_eop) begin
                        if (wcnt == 4'd11 && n_words == '0) begin
                            commit_now = 1'b1; state_n = COMMIT;
                        end else begin
                            drop_now = 1'b1; drop_code = 3'd7; state_n = IDLE;
                        end
                    end else if (wcnt == 4'd11) begin
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: if (bus.rx_eop) begin
                    if (!bus.rx_err && k_next >= n_words) begin
                        commit_now = 1'b1; state_n = COMMIT;
                    end else begin
                        drop_now = 1'b1; drop_code = 3'd7; state_n = IDLE;
                    end
                end
                DISCARD: if (bus.rx_eop) begin
                    drop_now = 1'b1; state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

    // Header capture, checksum accumulation, payload writes and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rx_rdy      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.mem_adr_wr  <= '0;
            bus.mem_data_wr <= '0;
            rx_length <= '0; src_ip <= '0; src_port <= '0; channel <= '0; time_buf <= '0;
            RX_DONE <= 1'b0; RX_DROP <= 1'b0; drop_cause <= '0;
            wcnt <= '0; mac_uni_q <= 1'b0; mac_bc_q <= 1'b0; dip_hi_q <= '0; csum_acc <= '0;
            n_words <= '0; pay_k <= '0; cause_q <= '0;
            plen_q <= '0; sport_q <= '0; sip_q <= '0; time_q <= '0; chan_q <= '0;
        end else begin
            bus.rx_rdy <= (state_n != COMMIT);
            bus.mem_wr <= 1'b0;
            RX_DONE    <= commit_now;
            RX_DROP    <= drop_now;
            if (drop_now)   drop_cause <= drop_code;
            if (go_discard) cause_q    <= hdr_cause;

            if (acc && bus.rx_sop && state != COMMIT) begin
                wcnt      <= 4'd1;
                pay_k     <= '0;
                mac_uni_q <= bus.rx_data == {mac[7:0], mac[15:8], mac[23:16], mac[31:24]};
                mac_bc_q  <= bus.rx_data == 32'hFFFF_FFFF;
            end else if (acc && state == HDR) begin
                wcnt <= wcnt + 4'd1;
                if (wcnt == 4'd3)
                    csum_acc <= {4'b0, bus.rx_data[15:0]};
                else if (wcnt >= 4'd4 && wcnt <= 4'd7)
                    csum_acc <= csum_acc + {4'b0, bus.rx_data[31:16]} + {4'b0, bus.rx_data[15:0]};
                case (wcnt)
                    4'd6:  sip_q[31:16] <= bus.rx_data[15:0];
                    4'd7:  begin sip_q[15:0] <= bus.rx_data[31:16]; dip_hi_q <= bus.rx_data[15:0]; end
                    4'd8:  sport_q <= bus.rx_data[15:0];
                    4'd9:  begin
                               plen_q  <= bus.rx_data[15:0] - 16'd14;
                               n_words <= NW'((bus.rx_data[15:0] - 16'd11) >> 2);
                           end
                    4'd10: chan_q <= bus.rx_data[7:0];
                    4'd11: time_q <= bus.rx_data;
                    default: ;
                endcase
            end else if (acc && state == PAYLOAD && pay_k < n_words) begin
                bus.mem_wr      <= 1'b1;
                bus.mem_adr_wr  <= pay_k[ADDR_W-1:0];
                bus.mem_data_wr <= bus.rx_data;
                pay_k           <= k_next;
            end

            if (commit_now) begin
                rx_length <= plen_q;
                src_ip    <= sip_q;
                src_port  <= sport_q;
                channel   <= chan_q;
                // A zero-payload datagram commits on W11 itself, before time_q is loaded
                time_buf  <= (state == HDR) ? bus.rx_data : time_q;
            end
        end
    end
endmodule
